// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and baud divider helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_e;

    // Clocks per bit period; integer division, caller guarantees a result >= 2.
    function automatic int uart_cycle(input int clk_frq, input int baud);
        return clk_frq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head word is read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM, LSB-first shifter, optional parity, registered TX line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FRQ    = 27000000,
    parameter int BAUD_RATE  = 3000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLE = uart_cycle(CLK_FRQ, BAUD_RATE);
    localparam int CW    = $clog2(CYCLE);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_out_q, tx_out_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 bit_end;
    logic                 load;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
    assign tx_out   = tx_out_q;
    assign bit_end  = (cyc_q == CYC_LAST);

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_out_d = 1'b1;
        fifo_pop = 1'b0;
        load     = 1'b0;

        if (state_q != ST_IDLE) cyc_d = bit_end ? '0 : cyc_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                tx_out_d = 1'b0;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_out_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                tx_out_d = par_q;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more data is waiting.
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            par_d    = (PARITY == PAR_ODD) ? ~(^fifo_head) : ^fifo_head;
            cyc_d    = '0;
            bit_d    = '0;
            state_d  = ST_START;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
        end
    end

endmodule
